// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
// Read hits answer combinationally; misses refill a 4-word line over memReq/memAck.
module data_cache #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        hit,
   output logic        stall,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   input  logic        memAck,
   input  logic [31:0] memRdata
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 28 - IW;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} stateType;

   stateType state, nextState;

   logic [LINES-1:0] validBits;
   logic [TW-1:0]    tagArray  [LINES];
   logic [31:0]      dataArray [LINES][WORDS];

   logic [1:0]    cnt;
   logic [TW-1:0] latTag;
   logic [IW-1:0] latIdx;
   logic [31:0]   latAddr;
   logic [31:0]   latData;

   logic [IW-1:0] reqIdx;
   logic [TW-1:0] reqTag;
   logic [1:0]    reqWord;
   logic          anyReq;
   logic          lastAck;

   assign reqIdx  = address[3+IW:4];
   assign reqTag  = address[31:4+IW];
   assign reqWord = address[3:2];
   assign anyReq  = memRead | memWrite;
   assign lastAck = memAck && (cnt == 2'd3);

   assign hit      = anyReq & validBits[reqIdx] & (tagArray[reqIdx] == reqTag);
   assign readData = anyReq ? dataArray[reqIdx][reqWord] : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         validBits <= '0;
         cnt       <= 2'd0;
         latTag    <= '0;
         latIdx    <= '0;
         latAddr   <= 32'd0;
         latData   <= 32'd0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (memWrite) begin
                  latAddr <= address & 32'hFFFF_FFFC;
                  latData <= writeData;
               end else if (memRead && !hit) begin
                  latTag            <= reqTag;
                  latIdx            <= reqIdx;
                  validBits[reqIdx] <= 1'b0;
                  cnt               <= 2'd0;
               end
            end
            REFILL: begin
               if (memAck) begin
                  cnt <= cnt + 2'd1;
                  if (lastAck) validBits[latIdx] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; validity alone decides whether it is used.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == IDLE && memWrite && hit)
            dataArray[reqIdx][reqWord] <= writeData;
         if (state == REFILL && memAck) begin
            dataArray[latIdx][cnt] <= memRdata;
            if (lastAck) tagArray[latIdx] <= latTag;
         end
      end
   end

   always_comb begin
      nextState = state;
      stall     = 1'b0;
      memReq    = 1'b0;
      memWe     = 1'b0;
      memAddr   = 32'd0;
      memWdata  = 32'd0;
      case (state)
         IDLE: begin
            if (memWrite) begin
               stall     = 1'b1;
               nextState = WRITE;
            end else if (memRead && !hit) begin
               stall     = 1'b1;
               nextState = REFILL;
            end
         end
         REFILL: begin
            stall   = 1'b1;
            memReq  = 1'b1;
            memAddr = {latTag, latIdx, cnt, 2'b00};
            if (lastAck) nextState = IDLE;
         end
         WRITE: begin
            memReq   = 1'b1;
            memWe    = 1'b1;
            memAddr  = latAddr;
            memWdata = latData;
            stall    = ~memAck;
            if (memAck) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - scoreboard bench for data_cache with reference cache/memory model
module tb_data_cache;
   logic        clk = 0;
   logic        rst;
   logic        memRead, memWrite;
   logic [31:0] address, writeData;
   logic [31:0] readData;
   logic        hit, stall;
   logic        memReq, memWe;
   logic [31:0] memAddr, memWdata;
   logic        memAck;
   logic [31:0] memRdata;

   data_cache #(.LINES(16), .WORDS(4)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
      .address(address), .writeData(writeData), .readData(readData),
      .hit(hit), .stall(stall), .memReq(memReq), .memWe(memWe),
      .memAddr(memAddr), .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          isWrite;
      bit          hit;
      logic [31:0] data;
      int          stallCycles;
   } respT;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } memTxnT;

   respT   expQ[$];
   memTxnT memQ[$];

   int nCompared = 0;
   int nMismatch = 0;
   bit monOn = 1;
   int ackDelay = 0;

   logic [31:0] physMem [int unsigned];
   logic [31:0] refMem  [int unsigned];
   bit          refValid [16];
   int unsigned refTag   [16];

   function automatic logic [31:0] initVal(input int unsigned w);
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] physRd(input int unsigned w);
      return physMem.exists(w) ? physMem[w] : initVal(w);
   endfunction

   function automatic logic [31:0] refRd(input int unsigned w);
      return refMem.exists(w) ? refMem[w] : initVal(w);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory responder: acks after ackDelay waiting cycles of each memReq word.
   initial begin
      int waitCnt = 0;
      memAck = 0;
      memRdata = 0;
      forever begin
         @(posedge clk);
         #1;
         memAck = 0;
         if (!memReq) waitCnt = 0;
         else if (waitCnt >= ackDelay) begin
            memAck = 1;
            waitCnt = 0;
            if (memWe) physMem[memAddr >> 2] = memWdata;
            else memRdata = physRd(memAddr >> 2);
         end else waitCnt++;
      end
   end

   // Monitor: pops expectations whenever the DUT completes a request or a memory beat.
   initial begin
      bit inFlight = 0;
      bit firstHit = 0;
      int stallCnt = 0;
      bit prevReq = 0, prevAck = 0;
      logic [31:0] prevAddr = 0;
      respT e;
      memTxnT m;
      forever begin
         @(negedge clk);
         if (rst || !monOn) begin
            inFlight = 0;
            stallCnt = 0;
         end else begin
            if (memRead || memWrite) begin
               if (!inFlight) begin
                  inFlight = 1;
                  firstHit = hit;
                  stallCnt = 0;
               end
               if (stall) stallCnt++;
               else begin
                  inFlight = 0;
                  if (expQ.size() == 0) check("unexpected_completion", 1, 0);
                  else begin
                     e = expQ.pop_front();
                     check("first_hit", firstHit, e.hit);
                     check("stall_cycles", stallCnt, e.stallCycles);
                     if (!e.isWrite) begin
                        check("final_hit", hit, 1);
                        check("readData", readData, e.data);
                     end
                  end
               end
            end else begin
               check("idle_outputs", {stall, hit, memReq}, 0);
               check("idle_readData", readData, 0);
            end
            if (memReq && prevReq && !prevAck) check("memAddr_stable", memAddr, prevAddr);
            if (memReq && memAck) begin
               if (memQ.size() == 0) check("unexpected_memAck", 1, 0);
               else begin
                  m = memQ.pop_front();
                  check("memWe", memWe, m.we);
                  check("memAddr", memAddr, m.addr);
                  if (m.we) check("memWdata", memWdata, m.data);
               end
            end
         end
         prevReq = memReq;
         prevAck = memAck;
         prevAddr = memAddr;
      end
   end

   task automatic doReq(input bit wr, input bit rdToo, input logic [31:0] a,
                        input logic [31:0] d, input int dly);
      int unsigned idx = (a >> 4) & 15;
      int unsigned tg = a >> 8;
      bit h = refValid[idx] && (refTag[idx] == tg);
      respT e;
      bit done = 0;
      e.isWrite = wr;
      e.hit = h;
      e.data = 0;
      if (wr) begin
         e.stallCycles = 1 + dly;
         refMem[a >> 2] = d;
         memQ.push_back('{1'b1, a & 32'hFFFF_FFFC, d});
      end else begin
         if (h) e.stallCycles = 0;
         else begin
            e.stallCycles = 1 + 4 * (dly + 1);
            for (int k = 0; k < 4; k++)
               memQ.push_back('{1'b0, (a & 32'hFFFF_FFF0) + 32'(4 * k), 32'd0});
            refValid[idx] = 1;
            refTag[idx] = tg;
         end
         e.data = refRd(a >> 2);
      end
      expQ.push_back(e);
      ackDelay = dly;
      @(posedge clk);
      #1;
      memWrite = wr;
      memRead = wr ? rdToo : 1'b1;
      address = a;
      writeData = wr ? d : $urandom;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1;
            break;
         end
      end
      if (!done) check("request_timeout", 1, 0);
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      memRead = 0;
      memWrite = 0;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic preload(input int unsigned w, input logic [31:0] v);
      physMem[w] = v;
      refMem[w] = v;
   endtask

   initial begin
      bit seen = 0;
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1;
      memRead = 0;
      memWrite = 0;
      address = 0;
      writeData = 0;
      for (int i = 0; i < 16; i++) refValid[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("reset_memReq_memWe", {memReq, memWe}, 0);
      check("reset_memAddr", memAddr, 0);
      check("reset_memWdata", memWdata, 0);
      check("reset_lookup", {stall, hit}, 0);
      check("reset_readData", readData, 0);

      preload(32'h40 >> 2, 32'h11);
      preload(32'h44 >> 2, 32'h22);
      preload(32'h48 >> 2, 32'h33);
      preload(32'h4C >> 2, 32'h44);
      doReq(0, 0, 32'h40, 0, 0);
      doReq(0, 0, 32'h48, 0, 0);
      idle(2);
      doReq(1, 0, 32'h44, 32'hDEAD_BEEF, 3);
      idle(1);
      doReq(0, 0, 32'h44, 0, 1);
      doReq(1, 0, 32'h1000, 32'hCAFE_0001, 0);
      doReq(0, 0, 32'h1000, 0, 0);
      doReq(0, 0, 32'h440, 0, 2);
      doReq(0, 0, 32'h40, 0, 0);
      idle(2);

      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         bit wr;
         a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
             ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         wr = ($urandom_range(0, 2) == 0);
         doReq(wr, $urandom_range(0, 1), a, $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(3);

      monOn = 0;
      ackDelay = 1;
      @(posedge clk);
      #1;
      memRead = 1;
      address = 32'h740;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (memAck) begin
            seen = 1;
            break;
         end
      end
      check("reset_test_first_ack", seen, 1);
      @(posedge clk);
      #1;
      rst = 1;
      memRead = 0;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("memReq_after_midrefill_reset", memReq, 0);
      check("stall_after_midrefill_reset", stall, 0);
      expQ.delete();
      memQ.delete();
      for (int i = 0; i < 16; i++) refValid[i] = 0;
      monOn = 1;
      doReq(0, 0, 32'h40, 0, 0);
      doReq(0, 0, 32'h740, 0, 0);
      idle(3);

      check("expQ_drained", expQ.size(), 0);
      check("memQ_drained", memQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
